sdio_host_cmd_phy: RTL and testbench

//  Host-side SDIO CMD-line PHY; opposite end of the device command PHY.

---
 rtl/sdio_host_cmd_phy.sv | 112 +++++++++++
 tb/tb_sdio_host_cmd_phy.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sdio_host_cmd_phy.sv
// sdio_host_cmd_phy: host CMD-line PHY, sends a 48-bit command and captures the 48-bit response
module sdio_host_cmd_phy #(
  parameter int NCR_MIN      = 2,
  parameter int RSPS_TIMEOUT = 64,
  parameter int NCC          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_stb,
  input  logic [5:0]  i_cmd,
  input  logic [31:0] i_cmd_arg,
  input  logic        i_rsps_en,
  input  logic        i_rsps_crc_chk,
  input  logic        i_abort,
  output logic        o_cmd_phy_idle,
  output logic        o_cmd_done_stb,
  output logic        o_rsps_stb,
  output logic [39:0] o_rsps,
  output logic        o_rsps_crc_good,
  output logic        o_rsps_end_good,
  output logic        o_timeout_stb,
  output logic        o_sdio_cmd_dir,
  output logic        o_sdio_cmd_out,
  input  logic        i_sdio_cmd_in
);
  typedef enum logic [2:0] {IDLE, CMD_TX, TURN, WAIT_START, RSPS_RX, GAP} state_t;
  state_t state, state_n;
  logic [5:0] cnt, cnt_n;
  logic done_n, rsps_n, to_n;
  logic [47:0] frame;
  logic [46:0] tx_sr, rx_sr;
  logic rsps_en_q, crc_chk_q;
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = {c[5:0], 1'b0} ^ ((d[i] ^ c[6]) ? 7'h09 : 7'h00);
    return c;
  endfunction
  assign frame = {2'b01, i_cmd, i_cmd_arg, crc7({2'b01, i_cmd, i_cmd_arg}), 1'b1};
  assign o_cmd_phy_idle = state == IDLE;
  // next state and strobe decode; the timeout compare uses TIMEOUT-2 so the registered
  // strobe lands RSPS_TIMEOUT cycles after the last turnaround cycle
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    rsps_n  = 1'b0;
    to_n    = 1'b0;
    if (i_abort) state_n = IDLE;
    else
      case (state)
        IDLE:       if (i_cmd_stb) state_n = CMD_TX;
        CMD_TX:     if (cnt == 6'd47) state_n = TURN;
        TURN:       if (cnt == 6'(NCR_MIN - 1)) begin
                      state_n = rsps_en_q ? WAIT_START : GAP;
                      done_n  = !rsps_en_q;
                    end
        WAIT_START: if (!i_sdio_cmd_in) state_n = RSPS_RX;
                    else if (cnt == 6'(RSPS_TIMEOUT - 2)) begin
                      state_n = GAP;
                      done_n  = 1'b1;
                      to_n    = 1'b1;
                    end
        RSPS_RX:    if (cnt == 6'd46) begin
                      state_n = GAP;
                      done_n  = 1'b1;
                      rsps_n  = 1'b1;
                    end
        GAP:        if (cnt == 6'(NCC - 1)) state_n = IDLE;
        default:    state_n = IDLE;
      endcase
    cnt_n = (state_n != state || state == IDLE) ? 6'd0 : cnt + 6'd1;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // pad drive, shift registers and response capture; rx_sr always holds the last 47 line samples
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt             <= '0;
      tx_sr           <= '0;
      rx_sr           <= '0;
      rsps_en_q       <= 1'b0;
      crc_chk_q       <= 1'b0;
      o_sdio_cmd_dir  <= 1'b0;
      o_sdio_cmd_out  <= 1'b1;
      o_cmd_done_stb  <= 1'b0;
      o_rsps_stb      <= 1'b0;
      o_timeout_stb   <= 1'b0;
      o_rsps          <= '0;
      o_rsps_crc_good <= 1'b0;
      o_rsps_end_good <= 1'b0;
    end else begin
      cnt            <= cnt_n;
      rx_sr          <= {rx_sr[45:0], i_sdio_cmd_in};
      tx_sr          <= (state == IDLE) ? frame[46:0] : {tx_sr[45:0], 1'b0};
      if (state == IDLE && state_n == CMD_TX) begin
        rsps_en_q <= i_rsps_en;
        crc_chk_q <= i_rsps_crc_chk;
      end
      o_sdio_cmd_dir <= state_n == CMD_TX;
      o_sdio_cmd_out <= state_n != CMD_TX || (state == IDLE ? frame[47] : tx_sr[46]);
      o_cmd_done_stb <= done_n;
      o_rsps_stb     <= rsps_n;
      o_timeout_stb  <= to_n;
      if (rsps_n) begin
        o_rsps          <= rx_sr[46:7];
        o_rsps_crc_good <= !crc_chk_q || crc7(rx_sr[46:7]) == rx_sr[6:0];
        o_rsps_end_good <= i_sdio_cmd_in;
      end
    end
endmodule

// File: tb/tb_sdio_host_cmd_phy.sv
// tb_sdio_host_cmd_phy: table-driven and randomized check of the host CMD PHY against a reference model
module tb_sdio_host_cmd_phy;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_stb = 1'b0, rsps_en = 1'b0, crc_chk = 1'b1, abort = 1'b0, cmd_in = 1'b1;
  logic [5:0] cmd = '0;
  logic [31:0] arg = '0;
  logic idle, done, rstb, crc_good, end_good, tout, dir, pad_out;
  logic [39:0] rsps;
  int n_vec = 0, n_bad = 0;
  logic [39:0] last_rsps = '0;

  always #5 clk = ~clk;

  sdio_host_cmd_phy dut (
    .clk(clk), .rst(rst), .i_cmd_stb(cmd_stb), .i_cmd(cmd), .i_cmd_arg(arg),
    .i_rsps_en(rsps_en), .i_rsps_crc_chk(crc_chk), .i_abort(abort),
    .o_cmd_phy_idle(idle), .o_cmd_done_stb(done), .o_rsps_stb(rstb), .o_rsps(rsps),
    .o_rsps_crc_good(crc_good), .o_rsps_end_good(end_good), .o_timeout_stb(tout),
    .o_sdio_cmd_dir(dir), .o_sdio_cmd_out(pad_out), .i_sdio_cmd_in(cmd_in)
  );

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] arg;
    bit          rsps_en;
    bit          crc_chk;
    int          delay;
    logic [47:0] rsp;
    bit          poke;
    logic [47:0] exp_frame;
    logic [39:0] exp_rsps;
    bit          exp_crc;
    bit          exp_end;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic vec_t mk(input logic [5:0] c, input logic [31:0] a, input bit re, input bit cc,
                              input int d, input logic [47:0] r, input bit p);
    vec_t v;
    v.cmd = c; v.arg = a; v.rsps_en = re; v.crc_chk = cc; v.delay = d; v.rsp = r; v.poke = p;
    v.exp_frame = {2'b01, c, a, crc_ref({2'b01, c, a}), 1'b1};
    v.exp_rsps  = r[47:8];
    v.exp_crc   = !cc || crc_ref(r[47:8]) == r[7:1];
    v.exp_end   = r[0];
    return v;
  endfunction

  task automatic run(input vec_t v);
    int c, done_c, idle_c, n_done, n_rs, n_to, exp_done, pad_bad;
    logic [47:0] got;
    logic [39:0] exp_r;
    bit dir_ok;
    c = 0;
    while (!idle && c < 40) begin tick; c++; end
    chk("pre_idle", idle, 1);
    cmd = v.cmd; arg = v.arg; rsps_en = v.rsps_en; crc_chk = v.crc_chk; cmd_stb = 1'b1;
    tick;
    cmd_stb = 1'b0; cmd = ~v.cmd; arg = ~v.arg; rsps_en = !v.rsps_en; crc_chk = !v.crc_chk;
    dir_ok = 1'b1; got = '0;
    for (int k = 0; k < 48; k++) begin
      dir_ok &= dir;
      got = {got[46:0], pad_out};
      cmd_stb = v.poke && k == 10;
      if (k < 47) tick;
    end
    cmd_stb = 1'b0;
    chk("frame", got, v.exp_frame);
    chk("dir_during_tx", dir_ok, 1);
    exp_done = v.delay < 0 ? (v.rsps_en ? 2 + 64 : 2 + 1) : v.delay + 48;
    done_c = -1; idle_c = -1; n_done = 0; n_rs = 0; n_to = 0; pad_bad = 0;
    for (c = 1; c <= 150; c++) begin
      tick;
      if (done) begin n_done++; if (done_c < 0) done_c = c; end
      n_rs += int'(rstb);
      n_to += int'(tout);
      if (dir || !pad_out) pad_bad++;
      if (idle) begin idle_c = c; break; end
      cmd_stb = v.poke && c == exp_done + 2;
      cmd_in = (v.delay >= 0 && c >= v.delay && c < v.delay + 48) ? v.rsp[47 - (c - v.delay)] : 1'b1;
    end
    cmd_stb = 1'b0; cmd_in = 1'b1;
    chk("done_cycle", done_c, exp_done);
    chk("done_pulses", n_done, 1);
    chk("rsps_pulses", n_rs, v.delay >= 0 ? 1 : 0);
    chk("timeout_pulses", n_to, (v.delay < 0 && v.rsps_en) ? 1 : 0);
    chk("idle_cycle", idle_c, exp_done + 8);
    chk("pad_released", pad_bad, 0);
    exp_r = v.delay >= 0 ? v.exp_rsps : last_rsps;
    chk("rsps", rsps, exp_r);
    last_rsps = exp_r;
    if (v.delay >= 0) begin
      chk("crc_good", crc_good, v.exp_crc);
      chk("end_good", end_good, v.exp_end);
    end
    if (v.poke) begin
      tick;
      tick;
      chk("stb_not_queued", {dir, idle}, 2'b01);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [39:0] body;
    logic [47:0] r;
    int mode, bit_i;
    bit re;
    tbl[0] = mk(6'd0, 32'h0, 1'b0, 1'b1, -1, 48'h0, 1'b1);
    tbl[0].exp_frame = 48'h400000000095;
    tbl[1] = mk(6'd8, 32'h1AA, 1'b1, 1'b1, 5, 48'h08000001AA13, 1'b0);
    tbl[1].exp_frame = 48'h48000001AA87; tbl[1].exp_rsps = 40'h08000001AA;
    tbl[1].exp_crc = 1'b1; tbl[1].exp_end = 1'b1;
    tbl[2] = mk(6'd8, 32'h1AA, 1'b1, 1'b1, 5, 48'h08000001AA13 ^ 48'h8, 1'b0);
    tbl[2].exp_frame = 48'h48000001AA87; tbl[2].exp_crc = 1'b0; tbl[2].exp_end = 1'b1;
    tbl[3] = mk(6'd8, 32'h1AA, 1'b1, 1'b0, 5, 48'h08000001AA13 ^ 48'h8, 1'b0);
    tbl[3].exp_frame = 48'h48000001AA87; tbl[3].exp_crc = 1'b1; tbl[3].exp_end = 1'b1;
    tbl[4] = mk(6'd5, 32'h0, 1'b1, 1'b1, -1, 48'h0, 1'b0);
    for (int i = 5; i < 12; i++) begin
      re = $urandom_range(0, 3) != 0;
      body = {2'b00, 6'($urandom_range(0, 63)), 32'($urandom)};
      r = {body, crc_ref(body), 1'b1};
      mode = $urandom_range(0, 3);
      bit_i = mode == 1 ? $urandom_range(1, 7) : mode == 2 ? 0 : $urandom_range(8, 45);
      if (mode != 0) r[bit_i] = !r[bit_i];
      tbl[i] = mk(6'($urandom_range(0, 63)), 32'($urandom), re, 1'($urandom_range(0, 1)),
                  re ? $urandom_range(3, 50) : -1, r, 1'($urandom_range(0, 1)));
    end

    tick;
    tick;
    chk("rst_dir", dir, 0);
    chk("rst_out", pad_out, 1);
    chk("rst_idle", idle, 1);
    chk("rst_rsps", rsps, 0);
    chk("rst_status", {done, rstb, tout, crc_good, end_good}, 0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 12; i++) run(tbl[i]);

    // abort together with a command strobe in IDLE drops the command
    cmd_stb = 1'b1; abort = 1'b1; cmd = 6'd8; arg = 32'h1AA;
    tick;
    cmd_stb = 1'b0; abort = 1'b0;
    chk("abort_vs_stb", {dir, idle}, 2'b01);
    tick;
    chk("abort_vs_stb_later", {dir, idle}, 2'b01);

    // abort while arg bit 20 (frame bit 28) is on the pad
    cmd = 6'd17; arg = 32'hDEADBEEF; rsps_en = 1'b1; cmd_stb = 1'b1;
    tick;
    cmd_stb = 1'b0;
    repeat (19) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_release", {dir, pad_out, idle}, 3'b011);
    chk("abort_no_stb", {done, rstb, tout}, 0);
    chk("abort_rsps_held", rsps, last_rsps);
    run(tbl[1]);

    // asynchronous reset in the middle of a response
    cmd = 6'd8; arg = 32'h1AA; rsps_en = 1'b1; crc_chk = 1'b1; cmd_stb = 1'b1;
    tick;
    cmd_stb = 1'b0;
    repeat (47) tick;
    for (int c = 1; c <= 30; c++) begin
      tick;
      cmd_in = c >= 5 ? tbl[1].rsp[47 - (c - 5)] : 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_pad", {dir, pad_out, idle}, 3'b011);
    chk("arst_rsps", rsps, 0);
    chk("arst_status", {done, rstb, tout, crc_good, end_good}, 0);
    tick;
    rst = 1'b0; cmd_in = 1'b1; last_rsps = '0;
    tick;
    chk("arst_idle_after", {dir, idle}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
